simplebus_initiator: RTL and testbench

- Synthesizable initiator for the SimpleBus multiplexed-address protocol. It accepts 16-bit read/write commands on a valid/ready interface and drives the two-cycle address phase on the 8-bit bus. For writes it drives the data phase; for reads it collects the responder's data phase, then returns a held response.
- It is the RTL replacement for the behavioural processor-side bus thread and pairs with the existing memory responder.
- The bus tri-states are split into out/oe/in triplets; the top-level wrapper resolves them onto the shared data and dataValid wires.

---
 rtl/simplebus_initiator.sv | 202 ++++++++++++++++++++
 tb/tb_simplebus_initiator.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simplebus_initiator.sv
// SimpleBus initiator: takes read/write commands and runs the
// two-cycle multiplexed address phase plus the data phase on the bus.
// Ports: clock, reset (sync, active-high); cmd_* command handshake in;
// rsp_* held response out; start/read/address bus strobes; data_* and
// dv_* out/oe/in triplets resolved by the wrapper onto the shared wires.
// Optional: define SIMPLEBUS_INIT_TIMEOUT_EN to end a read with an
// error response after READ_TIMEOUT wait cycles without dataValid.
module simplebus_initiator #(
  parameter int WRITE_DELAY  = 2,
  parameter int READ_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_read,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_read,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        start,
  output logic        read,
  output logic [7:0]  address,
  output logic [7:0]  data_out,
  output logic        data_oe,
  input  logic [7:0]  data_in,
  output logic        dv_out,
  output logic        dv_oe,
  input  logic        dv_in
);

  if (WRITE_DELAY < 2 || WRITE_DELAY > 7) begin : g_bad_wd
    $error("WRITE_DELAY must be in 2..7");
  end
  if (READ_TIMEOUT < 2 || READ_TIMEOUT > 255) begin : g_bad_rto
    $error("READ_TIMEOUT must be in 2..255");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_RD_WAIT,
    S_WR_WAIT,
    S_WR_DATA,
    S_RESP
  } state_e;

  // WR_WAIT lasts WRITE_DELAY-1 cycles: load N-2, leave on zero.
  localparam logic [2:0] DLY_LOAD = 3'(WRITE_DELAY - 2);

  state_e      state_q, state_d;
  logic        rd_q, rd_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [2:0]  dly_q, dly_d;
  logic [7:0]  rdata_q, rdata_d;

`ifdef SIMPLEBUS_INIT_TIMEOUT_EN
  localparam logic [7:0] RTO_LAST = 8'(READ_TIMEOUT - 1);
  logic        err_q, err_d;
  logic [7:0]  wait_q, wait_d;
`endif

  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    dly_d     = dly_q;
    rdata_d   = rdata_q;
`ifdef SIMPLEBUS_INIT_TIMEOUT_EN
    err_d     = err_q;
    wait_d    = wait_q;
`endif
    cmd_ready = 1'b0;
    start     = 1'b0;
    read      = 1'b0;
    address   = 8'h00;
    data_out  = 8'h00;
    data_oe   = 1'b0;
    dv_out    = 1'b0;
    dv_oe     = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          rd_d    = cmd_read;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          rdata_d = 8'h00;
`ifdef SIMPLEBUS_INIT_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = S_ADDR_HI;
        end
      end
      S_ADDR_HI: begin
        start   = 1'b1;
        address = addr_q[15:8];
        state_d = S_ADDR_LO;
      end
      S_ADDR_LO: begin
        address = addr_q[7:0];
        read    = rd_q;
        if (rd_q) begin
`ifdef SIMPLEBUS_INIT_TIMEOUT_EN
          wait_d  = 8'h00;
`endif
          state_d = S_RD_WAIT;
        end else begin
          dly_d   = DLY_LOAD;
          state_d = S_WR_WAIT;
        end
      end
      S_WR_WAIT: begin
        if (dly_q == 3'd0) state_d = S_WR_DATA;
        else dly_d = dly_q - 3'd1;
      end
      S_WR_DATA: begin
        data_oe  = 1'b1;
        data_out = wdata_q;
        dv_oe    = 1'b1;
        dv_out   = 1'b1;
        state_d  = S_RESP;
      end
      S_RD_WAIT: begin
`ifdef SIMPLEBUS_INIT_TIMEOUT_EN
        if (wait_q != 8'hFF) wait_d = wait_q + 8'd1;
`endif
        // dv_in beats a timeout landing in the same cycle
        if (dv_in) begin
          rdata_d = data_in;
          state_d = S_RESP;
        end
`ifdef SIMPLEBUS_INIT_TIMEOUT_EN
        else if (wait_q == RTO_LAST) begin
          rdata_d = 8'h00;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
`endif
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // The reset cycle itself must show a quiet bus.
    if (reset) begin
      cmd_ready = 1'b0;
      start     = 1'b0;
      read      = 1'b0;
      address   = 8'h00;
      data_out  = 8'h00;
      data_oe   = 1'b0;
      dv_out    = 1'b0;
      dv_oe     = 1'b0;
      rsp_valid = 1'b0;
    end
  end

  assign rsp_read  = rsp_valid & rd_q;
  assign rsp_rdata = rsp_valid ? rdata_q : 8'h00;
`ifdef SIMPLEBUS_INIT_TIMEOUT_EN
  assign rsp_err   = rsp_valid & err_q;
`else
  assign rsp_err   = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      rd_q    <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 8'h00;
      dly_q   <= 3'd0;
      rdata_q <= 8'h00;
`ifdef SIMPLEBUS_INIT_TIMEOUT_EN
      err_q   <= 1'b0;
      wait_q  <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dly_q   <= dly_d;
      rdata_q <= rdata_d;
`ifdef SIMPLEBUS_INIT_TIMEOUT_EN
      err_q   <= err_d;
      wait_q  <= wait_d;
`endif
    end
  end

endmodule

// File: tb/tb_simplebus_initiator.sv
// Bench for simplebus_initiator: random commands, memory reference
// model, bus-level responder, scoreboard-based monitors.
module tb_simplebus_initiator;
  localparam int WD  = 2;
  localparam int RTO = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_read = 1'b0;
  logic [15:0] cmd_addr = 16'h0;
  logic [7:0]  cmd_wdata = 8'h0;
  logic        rsp_ready = 1'b0;
  logic [7:0]  data_in = 8'h0;
  logic        dv_in = 1'b0;
  logic        cmd_ready, rsp_valid, rsp_read, rsp_err;
  logic [7:0]  rsp_rdata;
  logic        start, read, data_oe, dv_out, dv_oe;
  logic [7:0]  address, data_out;

  simplebus_initiator #(.WRITE_DELAY(WD), .READ_TIMEOUT(RTO)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_read(cmd_read), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_read(rsp_read), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .start(start), .read(read), .address(address),
    .data_out(data_out), .data_oe(data_oe), .data_in(data_in),
    .dv_out(dv_out), .dv_oe(dv_oe), .dv_in(dv_in)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic        rd;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        err;
    int          acc;
    int          lat;
    int          dly;
  } item_t;

  item_t      qbus[$];
  item_t      qrsp[$];
  logic [7:0] mmem[int];
  logic [7:0] rmem[int];

  int errs = 0;
  int checks = 0;
  int hold_until = 0;
  int pulse_req = -1;
  bit rd_active = 0;
  int rd_fire = -1;
  int pulse_cyc = -1;
  logic [15:0] rd_addr = 16'h0;

  function automatic logic [7:0] ival(input logic [15:0] a);
    return a[15:8] ^ a[7:0] ^ 8'h5A;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Responder: answers reads, injects stray dataValid otherwise.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (rd_active && cyc == rd_fire) begin
        dv_in   = 1'b1;
        data_in = rmem.exists(int'(rd_addr)) ? rmem[int'(rd_addr)]
                                            : ival(rd_addr);
      end else if (cyc == pulse_req) begin
        dv_in   = 1'b1;
        data_in = 8'($urandom);
      end else begin
        dv_in   = !rd_active && ($urandom_range(0, 3) == 0);
        data_in = 8'($urandom);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      #1;
      rsp_ready = (cyc >= hold_until) && ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: bus phases and responses against the scoreboard.
  item_t       cur, ex;
  logic [15:0] busa = 16'h0;
  int          lo_due = -1;
  int          wr_due = -1;
  bit          prev_start = 0, prev_rv = 0, prev_hs = 0, prev_rst = 1;
  logic [9:0]  prev_rsp = 10'h0;

  always @(negedge clock) begin
    if (reset) begin
      chk("rst_outs", 64'({start, read, address, data_out, data_oe, dv_out,
          dv_oe, cmd_ready, rsp_valid, rsp_read, rsp_err, rsp_rdata}), 64'd0);
      qbus.delete();
      qrsp.delete();
      lo_due = -1;
      wr_due = -1;
      rd_active = 0;
      rd_fire = -1;
      prev_start = 0;
      prev_rv = 0;
      prev_hs = 0;
      prev_rst = 1;
    end else begin
      if (prev_rst) chk("ready_after_rst", 64'(cmd_ready), 64'd1);
      if (prev_hs)
        chk("idle_after_rsp", 64'({cmd_ready, start, rsp_valid}), 64'(3'b100));
      if (rd_active && rd_fire >= 0 && cyc >= rd_fire) rd_active = 0;
      if (start) begin
        chk("start_adj", 64'(prev_start), 64'd0);
        if (qbus.size() == 0) chk("start_unexp", 64'd1, 64'd0);
        else begin
          cur = qbus.pop_front();
          chk("start_lat", 64'(cyc), 64'(cur.acc));
          chk("addr_hi", 64'({read, address}), 64'({1'b0, cur.addr[15:8]}));
          busa[15:8] = address;
          lo_due = cyc + 1;
        end
      end
      if (cyc == lo_due) begin
        chk("addr_lo", 64'({start, read, address}),
            64'({1'b0, cur.rd, cur.addr[7:0]}));
        busa[7:0] = address;
        if (cur.rd) begin
          rd_active = 1;
          rd_addr   = busa;
          rd_fire   = (cur.dly < 0) ? -1 : cyc + 1 + cur.dly;
          pulse_cyc = rd_fire;
        end else wr_due = cyc + WD;
      end else if (!start) begin
        chk("bus_idle", 64'({read, address}), 64'd0);
      end
      if (data_oe || dv_oe || cyc == wr_due) begin
        chk("wr_phase", 64'({data_oe, dv_oe, dv_out, data_out}),
            64'({3'b111, cur.wdata}));
        chk("wr_time", 64'(cyc), 64'(wr_due));
        if (data_oe) rmem[int'(busa)] = data_out;
      end
      if (rsp_valid) begin
        rd_active = 0;
        chk("rsp_busy", 64'({cmd_ready, start}), 64'd0);
        if (qrsp.size() == 0) chk("rsp_unexp", 64'd1, 64'd0);
        else begin
          ex = qrsp[0];
          if (!prev_rv || prev_hs)
            chk("rsp_lat", 64'(cyc), 64'(ex.lat >= 0 ? ex.lat : pulse_cyc + 1));
          else
            chk("rsp_stable", 64'({rsp_read, rsp_err, rsp_rdata}), 64'(prev_rsp));
          if (rsp_ready) begin
            void'(qrsp.pop_front());
            chk("rsp_data", 64'({rsp_read, rsp_err, rsp_rdata}),
                64'({ex.rd, ex.err, ex.rdata}));
          end
        end
      end else if (prev_rv && !prev_hs) begin
        chk("rsp_drop", 64'd1, 64'd0);
      end
      prev_rst   = 0;
      prev_start = start;
      prev_rv    = rsp_valid;
      prev_hs    = rsp_valid && rsp_ready;
      prev_rsp   = {rsp_read, rsp_err, rsp_rdata};
    end
  end

  // dly: -1 random responder delay, -2 responder never answers.
  task automatic issue(input logic rd, input logic [15:0] a,
                       input logic [7:0] wd, input int dly);
    item_t it;
    int    n = 0;
    bit    ok = 0;
    cmd_valid = 1'b1;
    cmd_read  = rd;
    cmd_addr  = a;
    cmd_wdata = wd;
    while (!ok && n < 200) begin
      @(negedge clock);
      if (cmd_ready && !reset) ok = 1;
      else begin
        n++;
        @(posedge clock);
        #1;
      end
    end
    chk("accept", 64'(ok), 64'd1);
    if (ok) begin
      it.rd    = rd;
      it.addr  = a;
      it.wdata = wd;
      it.acc   = cyc + 1;
      it.err   = 1'b0;
      it.rdata = 8'h00;
      it.dly   = (dly == -1) ? int'($urandom_range(0, 6)) : dly;
      if (rd) begin
        it.rdata = mmem.exists(int'(a)) ? mmem[int'(a)] : ival(a);
        it.lat   = -1;
        if (dly == -2) begin
          it.rdata = 8'h00;
          it.err   = 1'b1;
          it.lat   = it.acc + 2 + RTO;
        end
      end else begin
        mmem[int'(a)] = wd;
        it.lat = it.acc + 2 + WD;
      end
      qbus.push_back(it);
`ifdef SIMPLEBUS_INIT_TIMEOUT_EN
      qrsp.push_back(it);
`else
      if (dly != -2) qrsp.push_back(it);
`endif
    end
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((qbus.size() != 0 || qrsp.size() != 0) && n < 300) begin
      @(posedge clock);
      n++;
    end
    #1;
    chk("drain", 64'(n < 300), 64'd1);
  endtask

  task automatic pulse_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  logic [15:0] pool [4];

  initial begin
    pool[0] = 16'h0406;
    pool[1] = 16'hFFFF;
    pool[2] = 16'h0000;
    pool[3] = 16'h1234;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    issue(1'b0, 16'h0406, 8'hDC, -1);
    issue(1'b1, 16'h0406, 8'h00, 2);
    wait_drain();
    // Response held under back-pressure with a command waiting.
    hold_until = cyc + 14;
    issue(1'b0, 16'h1234, 8'h77, -1);
    issue(1'b1, 16'h1234, 8'h00, -1);
    wait_drain();
    for (int i = 0; i < 60; i++) begin
      logic [15:0] a;
      int k;
      k = $urandom_range(0, 4);
      a = (k == 4) ? 16'($urandom) : pool[k];
      if ($urandom_range(0, 9) == 0) hold_until = cyc + 8;
      issue(1'($urandom_range(0, 1)), a, 8'($urandom), -1);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock);
        #1;
      end
    end
    wait_drain();
    // Read with no dataValid at all.
    issue(1'b1, 16'h0BAD, 8'h00, -2);
`ifdef SIMPLEBUS_INIT_TIMEOUT_EN
    wait_drain();
`else
    repeat (100) @(posedge clock);
    @(negedge clock);
    chk("still_waiting", 64'({rsp_valid, cmd_ready}), 64'd0);
    pulse_reset();
`endif
    // Reset in RD_WAIT, then a late dataValid pulse.
    issue(1'b1, 16'h0406, 8'h00, -2);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    pulse_req = cyc + 2;
    repeat (10) @(posedge clock);
    @(negedge clock);
    chk("quiet_after_rst", 64'({rsp_valid, start, data_oe, dv_oe}), 64'd0);
    @(posedge clock);
    #1;
    issue(1'b0, 16'hFFFF, 8'h1A, -1);
    issue(1'b1, 16'hFFFF, 8'h00, -1);
    wait_drain();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: no finish by cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
